// File: rtl/pes_freq_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pes_freq_meter : measures period and high time of sig_in in clkin cycles.
// Optional lock checker enabled by macro PES_FREQ_METER_LOCK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pes_freq_meter #(
  parameter int CW = 8
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sig_in,
`ifdef PES_FREQ_METER_LOCK_EN
  input  logic [CW-1:0] n_exp,
  output logic          lock,
`endif
  output logic [CW-1:0] period,
  output logic [CW-1:0] high,
  output logic          valid,
  output logic          stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_MAX = '1;
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic          sync1_q, sync2_q, dly_q, rise_q;
  logic [CW-1:0] cnt_q, hcnt_q;
  logic [CW-1:0] period_q, high_q;
  logic          valid_q, stall_q;

  logic [CW-1:0] cnt_d, hcnt_d, hcnt_init_d;
  logic          cap_d, tout_entry_d;

  // dly_q is the synchronized level aligned with rise_q, so the rise cycle itself counts high
  always_comb begin
    cnt_d        = (cnt_q == C_MAX) ? cnt_q : cnt_q + C_ONE;
    hcnt_d       = (hcnt_q == C_MAX || !dly_q) ? hcnt_q : hcnt_q + C_ONE;
    hcnt_init_d  = {{(CW-1){1'b0}}, dly_q};
    cap_d        = en && (state_q == MEAS) && rise_q;
    tout_entry_d = en && (state_q == MEAS) && !rise_q && (cnt_q == C_MAX);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      rise_q  <= sync2_q & ~dly_q;
      valid_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        stall_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARM;
          end
          ARM: begin
            if (rise_q) begin
              state_q <= MEAS;
              cnt_q   <= C_ONE;
              hcnt_q  <= hcnt_init_d;
            end
          end
          MEAS: begin
            if (rise_q) begin
              period_q <= cnt_q;
              high_q   <= hcnt_q;
              valid_q  <= 1'b1;
              cnt_q    <= C_ONE;
              hcnt_q   <= hcnt_init_d;
            end else if (cnt_q == C_MAX) begin
              state_q <= TOUT;
              stall_q <= 1'b1;
            end else begin
              cnt_q  <= cnt_d;
              hcnt_q <= hcnt_d;
            end
          end
          TOUT: begin
            if (rise_q) begin
              state_q <= MEAS;
              stall_q <= 1'b0;
              cnt_q   <= C_ONE;
              hcnt_q  <= hcnt_init_d;
            end else begin
              cnt_q  <= cnt_d;
              hcnt_q <= hcnt_d;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign period = period_q;
  assign high   = high_q;
  assign valid  = valid_q;
  assign stall  = stall_q;

`ifdef PES_FREQ_METER_LOCK_EN
  logic lock_q, match_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      match_q <= 1'b0;
    end else if (!en || tout_entry_d) begin
      lock_q  <= 1'b0;
      match_q <= 1'b0;
    end else if (cap_d) begin
      if (cnt_q == n_exp) begin
        lock_q  <= match_q;
        match_q <= 1'b1;
      end else begin
        lock_q  <= 1'b0;
        match_q <= 1'b0;
      end
    end
  end

  assign lock = lock_q;
`else
  logic unused_lock_d;
  assign unused_lock_d = cap_d ^ tout_entry_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pes_freq_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pes_freq_meter : directed vector bench for pes_freq_meter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pes_freq_meter;

  localparam int CW = 8;

  logic          clkin = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period, high;
  logic          valid, stall;
`ifdef PES_FREQ_METER_LOCK_EN
  logic [CW-1:0] n_exp = 8'd6;
  logic          lock;
`endif

  pes_freq_meter #(.CW(CW)) dut (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .en     (en),
    .sig_in (sig_in),
`ifdef PES_FREQ_METER_LOCK_EN
    .n_exp  (n_exp),
    .lock   (lock),
`endif
    .period (period),
    .high   (high),
    .valid  (valid),
    .stall  (stall)
  );

  always #5 clkin = ~clkin;

  int ncmp = 0;
  int nfail = 0;
  int vcount = 0;
  int hi_len = 2;
  int lo_len = 2;
  bit run = 1'b0;

  // sig_in pattern generator: changes 3 time units after each clkin rise
  initial begin : pattern
    int ph;
    ph = 0;
    forever begin
      @(posedge clkin);
      #3;
      if (!run) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        sig_in = (ph < hi_len);
        ph = (ph >= hi_len + lo_len - 1) ? 0 : ph + 1;
      end
    end
  end

  initial begin : valid_mon
    forever begin
      @(posedge clkin);
      #1;
      if (valid) vcount++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int budget, output int cycles);
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clkin);
      #1;
      if (valid) begin
        cycles = i;
        return;
      end
    end
    ncmp++;
    nfail++;
    $display("FAIL %s: got no valid, expected one within %0d cycles", name, budget);
  endtask

  task automatic restart(input int h, input int l);
    @(negedge clkin);
    run = 1'b0;
    en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    hi_len = h;
    lo_len = l;
    en = 1'b1;
    run = 1'b1;
  endtask

  typedef struct {
    int hi;
    int lo;
    int per;
    int hgh;
  } vec_t;

  vec_t tbl[8];

  initial begin : main
    int c;
    int v0;
    int n;
    bit found;

    tbl[0] = '{2, 2, 4, 2};
    tbl[1] = '{1, 1, 2, 1};
    tbl[2] = '{3, 2, 5, 3};
    tbl[3] = '{1, 3, 4, 1};
    tbl[4] = '{4, 1, 5, 4};
    tbl[5] = '{5, 5, 10, 5};
    tbl[6] = '{1, 2, 3, 1};
    tbl[7] = '{100, 27, 127, 100};

    // reset state
    repeat (3) @(negedge clkin);
    check("reset_period", int'(period), 0);
    check("reset_high", int'(high), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_stall", int'(stall), 0);

    // divide-by-4: first rise only arms, valid comes one period later
    restart(2, 2);
    wait_valid("div4_first", 30, c);
    check("div4_first_valid_cycle", c, 9);
    check("div4_first_period", int'(period), 4);
    check("div4_first_high", int'(high), 2);
    @(posedge clkin);
    #1;
    check("div4_valid_one_cycle", int'(valid), 0);

    // table of periodic patterns
    for (int t = 0; t < 8; t++) begin
      restart(tbl[t].hi, tbl[t].lo);
      for (int j = 0; j < 3; j++) begin
        wait_valid($sformatf("tbl%0d_wait%0d", t, j), 3 * tbl[t].per + 20, c);
        check($sformatf("tbl%0d_period%0d", t, j), int'(period), tbl[t].per);
        check($sformatf("tbl%0d_high%0d", t, j), int'(high), tbl[t].hgh);
      end
    end

    // timeout: sig_in held low after one measurement
    restart(2, 2);
    wait_valid("tout_wait", 30, c);
    run = 1'b0;
    @(negedge clkin);
    v0 = vcount;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clkin);
      #1;
      if (stall) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    check("tout_stall_seen", int'(found), 1);
    check("tout_stall_cycle", n, 255);
    repeat (10) @(negedge clkin);
    check("tout_stall_held", int'(stall), 1);
    check("tout_period_hold", int'(period), 4);
    check("tout_high_hold", int'(high), 2);
    check("tout_no_valid", vcount - v0, 0);
    run = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clkin);
      #1;
      if (!stall) begin
        found = 1'b1;
        break;
      end
    end
    check("tout_stall_cleared", int'(found), 1);
    check("tout_exit_no_valid", int'(valid), 0);
    @(negedge clkin);
    check("tout_exit_vcount", vcount - v0, 0);
    wait_valid("tout_fresh_wait", 20, c);
    check("tout_fresh_period", int'(period), 4);
    check("tout_fresh_high", int'(high), 2);
    check("tout_fresh_stall", int'(stall), 0);

    // reset mid-window
    restart(5, 5);
    wait_valid("rstmid_wait", 50, c);
    repeat (4) @(negedge clkin);
    rst_n = 1'b0;
    @(posedge clkin);
    #1;
    check("rstmid_period", int'(period), 0);
    check("rstmid_high", int'(high), 0);
    check("rstmid_valid", int'(valid), 0);
    check("rstmid_stall", int'(stall), 0);
    @(negedge clkin);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (8) @(negedge clkin);
    check("rstmid_no_valid", vcount - v0, 0);

    // en low mid-window
    restart(5, 5);
    wait_valid("enlow_wait", 50, c);
    repeat (4) @(negedge clkin);
    en = 1'b0;
    v0 = vcount;
    repeat (20) @(negedge clkin);
    check("enlow_no_valid", vcount - v0, 0);
    check("enlow_period_hold", int'(period), 10);
    check("enlow_high_hold", int'(high), 5);
    check("enlow_stall", int'(stall), 0);
    en = 1'b1;
    wait_valid("enlow_resume", 50, c);
    check("enlow_resume_period", int'(period), 10);
    check("enlow_resume_high", int'(high), 5);

`ifdef PES_FREQ_METER_LOCK_EN
    // lock checker with n_exp=6
    restart(3, 3);
    wait_valid("lock_v1", 40, c);
    check("lock_after_v1", int'(lock), 0);
    wait_valid("lock_v2", 40, c);
    check("lock_after_v2", int'(lock), 1);
    wait_valid("lock_v3", 40, c);
    check("lock_after_v3", int'(lock), 1);
    lo_len = 4;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_valid("lock_div7", 40, c);
      if (period != 8'd6) begin
        found = 1'b1;
        break;
      end
    end
    check("lock_div7_seen", int'(found), 1);
    check("lock_cleared", int'(lock), 0);
    wait_valid("lock_div7_next", 40, c);
    check("lock_div7_period", int'(period), 7);
    check("lock_stays_clear", int'(lock), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pes_freq_meter.md
PES_FREQ_METER -- requirements
Module: pes_freq_meter

Interface
REQ-001 SHALL have parameter CW, default 8: width of the period and high-time counters and outputs.
REQ-002 SHALL have port clkin  input  1  the single clock; all flops are clocked on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous to clkin and active-low.
REQ-004 SHALL have port en  input  1  measurement enable; a low level forces IDLE.
REQ-005 SHALL have port sig_in  input  1  clock under test (e.g. a divided clock), asynchronous to clkin.
REQ-006 SHALL have port period  output  CW  clkin cycles per sig_in period, registered.
REQ-007 SHALL have port high  output  CW  clkin cycles sig_in was sampled high within that period, registered.
REQ-008 SHALL have port valid  output  1  one-cycle strobe when period and high update.
REQ-009 SHALL have port stall  output  1  high while in TOUT.

Function
REQ-010 SHALL pass sig_in through a 2-flop synchronizer followed by one delay flop.
- rise = synchronized level high and delayed level low.
- sig_in first sampled high at edge k: rise is true after edge k+2; outputs update at edge k+3.
REQ-011 SHALL implement FSM states IDLE, ARM, MEAS and TOUT.
REQ-012 SHALL transition as follows.
- IDLE->ARM when en=1.
- ARM->MEAS on rise; this first rise produces no valid.
- MEAS->MEAS on rise, with capture.
- MEAS->TOUT on counter saturation.
- TOUT->MEAS on rise; this rise restarts counting and produces no valid.
- Any state->IDLE when en=0.
REQ-013 SHALL count period as the clkin cycles from one rise cycle, inclusive, up to the next rise cycle, exclusive. A divide-by-n input with n>=2 yields period=n.
REQ-014 SHALL count high as the cycles in the same window whose synchronized level is 1.
REQ-015 SHALL, on each rise in MEAS, load period and high and pulse valid for exactly one cycle. The counters restart so that the rise cycle counts as cycle 1 of the next window.
REQ-016 SHALL report a minimum period of 2: sig_in at clkin/2 gives period=2, high=1.
REQ-017 SHALL enter TOUT when the period counter reaches 2^CW-1 without a rise. Counters saturate in TOUT. period and high hold, and valid stays 0.
REQ-018 SHALL keep stall=1 in TOUT and clear it in the cycle the FSM leaves TOUT.
REQ-019 SHALL, when en=0, clear the counters and valid and hold period and high at their last values.
REQ-020 SHALL, when en falls mid-window, abandon that window; a later en=1 restarts at ARM.
REQ-021 SHALL keep the synchronizer flops running regardless of en.

Reset
REQ-022 SHALL, when rst_n=0 at a clkin edge, set the FSM to IDLE, all counters and synchronizer flops to 0, period=0, high=0, valid=0 and stall=0.
REQ-023 SHALL give reset priority over en and rise. Reset mid-window discards the partial measurement and produces no valid.

Configuration
REQ-024 SHALL compile the lock checker in only when macro PES_FREQ_METER_LOCK_EN is defined.
REQ-025 SHALL, with PES_FREQ_METER_LOCK_EN defined, add two ports.
- Input n_exp, width CW: expected period.
- Output lock, width 1, reset 0.
REQ-026 SHALL, with PES_FREQ_METER_LOCK_EN defined, drive lock as follows.
- Set lock on the second consecutive valid with period==n_exp.
- Clear lock on any valid with period!=n_exp, on entry to TOUT, or when en=0.
- Clearing restarts the consecutive-match count.
REQ-027 SHALL, without PES_FREQ_METER_LOCK_EN, omit n_exp, lock and all lock logic; the remaining behaviour is unchanged.

Verification
REQ-028 SHALL cover reset then en=1 with sig_in driven by a divide-by-4 of clkin: the first rise gives no valid, and each later rise gives valid=1 with period=4, high=2.
REQ-029 SHALL cover sig_in as a clkin/2 toggle: every valid reports period=2, high=1.
REQ-030 SHALL cover sig_in driven 3 high / 2 low, aligned to clkin: period=5, high=3.
REQ-031 SHALL cover CW=8 with sig_in held low after one measurement: stall=1 once the counter reaches 255, and period/high hold. The next rise clears stall without valid, and the following rise gives a fresh valid.
REQ-032 SHALL cover rst_n=0 and, separately, en=0 mid-window: no valid is produced, and outputs match REQ-022 and REQ-019 respectively.
REQ-033 SHALL cover, with PES_FREQ_METER_LOCK_EN and n_exp=6, a divide-by-6 input: lock=1 after the second valid. Switching the input to divide-by-7 clears lock on the next valid.
